// File: rtl/slice_event_tx.sv
// Slice-event FIFO and software handshake: queues slice-detection events and presents them one at a time on a PIO word.
// Optional macro SLICE_EVENT_TX_SYNC_EN adds a two-flop synchronizer on the software handshake input.
module slice_event_tx #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [1:0]  ev_kind,
    input  logic [3:0]  ev_sprite,
    input  logic [9:0]  ev_x,
    input  logic [9:0]  ev_y,
    output logic [31:0] to_sw_data,
    output logic [1:0]  to_sw_sig,
    input  logic [1:0]  to_hw_sig,
    output logic [4:0]  level,
    output logic [7:0]  overflow_cnt
);
    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RELEASE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      sig_q, sig_d;
    logic [31:0]     data_q, data_d;
    logic [3:0]      seq_q, seq_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      level_q, level_d;
    logic [7:0]      ovf_q, ovf_d;
    logic [25:0]     fifo_mem [FIFO_DEPTH];
    logic [25:0]     head;
    logic [1:0]      ack_sig;
    logic            full, flush, push, pop, drop;

`ifdef SLICE_EVENT_TX_SYNC_EN
    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = to_hw_sig;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign ack_sig = sync2_q;
`else
    assign ack_sig = to_hw_sig;
`endif

    // ev_ready looks at registered occupancy only, so a pop never frees a slot in the same cycle
    assign full     = (level_q == DEPTH_L);
    assign flush    = (ack_sig == 2'b11);
    assign push     = ev_valid && !full && !flush;
    assign drop     = ev_valid && full;
    assign pop      = (state_q == IDLE) && (level_q != 5'd0) && !flush;
    assign head     = fifo_mem[rd_ptr_q];

    assign ev_ready     = !full;
    assign to_sw_data   = data_q;
    assign to_sw_sig    = sig_q;
    assign level        = level_q;
    assign overflow_cnt = ovf_q;

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        data_d   = data_q;
        seq_d    = seq_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;

        case ({push, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    data_d   = {head[25:20], seq_q, 2'b00, head[19:0]};
                    sig_d    = 2'b01;
                    seq_d    = seq_q + 4'd1;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_sig == 2'b01) begin
                    sig_d   = 2'b00;
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (ack_sig == 2'b00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over everything, including a push in the same cycle
        if (flush) begin
            state_d  = IDLE;
            sig_d    = 2'b00;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = 5'd0;
            ovf_d    = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sig_q    <= 2'b00;
            data_q   <= 32'd0;
            seq_q    <= 4'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 5'd0;
            ovf_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            sig_q    <= sig_d;
            data_q   <= data_d;
            seq_q    <= seq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage only; validity is tracked by the pointers and level
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {ev_kind, ev_sprite, ev_x, ev_y};
    end
endmodule
